// File: rtl/defs_memoria.sv
// Purpose: encodings shared by the store unit and the matching load unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package defs_memoria;

  // Access width as encoded in the control word from the decoder.
  typedef enum logic [1:0] {
    TIPO_SB  = 2'b00,
    TIPO_SH  = 2'b01,
    TIPO_SW  = 2'b10,
    TIPO_RES = 2'b11
  } tipo_t;

  // Failure cause reported to the control unit alongside done.
  typedef enum logic [1:0] {
    CAUSA_NENHUMA     = 2'b00,
    CAUSA_DESALINHADO = 2'b01,
    CAUSA_TIPO        = 2'b10,
    CAUSA_TIMEOUT     = 2'b11
  } causa_t;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    ESCRITA  = 2'b01,
    RESPOSTA = 2'b10
  } estado_t;

  // Default write wait budget; the wait counter is 8 bits wide.
  localparam int unsigned MAX_WAIT_PADRAO = 255;

endpackage

// File: rtl/alinhador_de_store.sv
// Purpose: narrows a store value to SB/SH/SW width and places it on the byte lanes.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
// Ports: tipo (store type), endereco_lo (address[1:0]), dado (rt value) in;
//        mem_dado, mem_byte_en (lane data/enables), desalinhado, tipo_invalido out.
module alinhador_de_store
  import defs_memoria::*;
(
  input  logic [1:0]  tipo,
  input  logic [1:0]  endereco_lo,
  input  logic [31:0] dado,
  output logic [31:0] mem_dado,
  output logic [3:0]  mem_byte_en,
  output logic        desalinhado,
  output logic        tipo_invalido
);

  always_comb begin
    mem_dado      = dado;
    mem_byte_en   = 4'b0000;
    desalinhado   = 1'b0;
    tipo_invalido = 1'b0;
    case (tipo_t'(tipo))
      TIPO_SB: begin
        // Replicating the byte lets memory pick the lane purely by byte enable.
        mem_dado    = {4{dado[7:0]}};
        mem_byte_en = 4'b0001 << endereco_lo;
      end
      TIPO_SH: begin
        mem_dado    = {2{dado[15:0]}};
        mem_byte_en = endereco_lo[1] ? 4'b1100 : 4'b0011;
        desalinhado = endereco_lo[0];
      end
      TIPO_SW: begin
        mem_byte_en = 4'b1111;
        desalinhado = (endereco_lo != 2'b00);
      end
      default: begin
        tipo_invalido = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/unidade_de_store.sv
// Purpose: store unit; accepts SB/SH/SW from control, issues one lane-placed word write.
// Latency: done 2 cycles after acceptance with immediate mem_ready, 1 cycle for illegal requests.
// Backpressure: req_ready low while a store is in flight; waits on mem_ready up to MAX_WAIT cycles.
// Ports: clock/reset; req_valid/req_ready/req_tipo/req_endereco/req_dado from control;
//        mem_valid/mem_ready/mem_endereco/mem_dado/mem_byte_en to memory; done/erro/erro_causa status.
module unidade_de_store
  import defs_memoria::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_tipo,
  input  logic [31:0] req_endereco,
  input  logic [31:0] req_dado,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_endereco,
  output logic [31:0] mem_dado,
  output logic [3:0]  mem_byte_en,
  output logic        done,
  output logic        erro,
  output logic [1:0]  erro_causa
);

  localparam logic [7:0] ULTIMA_ESPERA = 8'(MAX_WAIT - 1);

  estado_t     state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_end_q, mem_end_d;
  logic [31:0] mem_dado_q, mem_dado_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        done_q, done_d;
  logic        erro_q, erro_d;
  causa_t      causa_q, causa_d;

  logic [31:0] al_dado;
  logic [3:0]  al_be;
  logic        al_desalinhado;
  logic        al_tipo_invalido;

  alinhador_de_store u_alinhador (
    .tipo          (req_tipo),
    .endereco_lo   (req_endereco[1:0]),
    .dado          (req_dado),
    .mem_dado      (al_dado),
    .mem_byte_en   (al_be),
    .desalinhado   (al_desalinhado),
    .tipo_invalido (al_tipo_invalido)
  );

  // done/erro/erro_causa are computed on the transition into RESPOSTA so they
  // come straight from flops and are zero in every other state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    mem_valid_d = mem_valid_q;
    mem_end_d   = mem_end_q;
    mem_dado_d  = mem_dado_q;
    mem_be_d    = mem_be_q;
    done_d      = 1'b0;
    erro_d      = 1'b0;
    causa_d     = CAUSA_NENHUMA;
    case (state_q)
      OCIOSO: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          if (al_tipo_invalido || al_desalinhado) begin
            // Reserved type outranks misalignment; memory is never touched.
            state_d = RESPOSTA;
            done_d  = 1'b1;
            erro_d  = 1'b1;
            causa_d = al_tipo_invalido ? CAUSA_TIPO : CAUSA_DESALINHADO;
          end else begin
            state_d     = ESCRITA;
            mem_valid_d = 1'b1;
            cnt_d       = 8'd0;
            mem_end_d   = {req_endereco[31:2], 2'b00};
            mem_dado_d  = al_dado;
            mem_be_d    = al_be;
          end
        end
      end
      ESCRITA: begin
        if (mem_ready) begin
          // Handshake wins even on the final allowed wait cycle.
          state_d     = RESPOSTA;
          mem_valid_d = 1'b0;
          mem_be_d    = 4'b0000;
          done_d      = 1'b1;
        end else if (cnt_q == ULTIMA_ESPERA) begin
          state_d     = RESPOSTA;
          mem_valid_d = 1'b0;
          mem_be_d    = 4'b0000;
          done_d      = 1'b1;
          erro_d      = 1'b1;
          causa_d     = CAUSA_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESPOSTA: begin
        state_d     = OCIOSO;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = OCIOSO;
        req_ready_d = 1'b1;
        mem_valid_d = 1'b0;
        mem_be_d    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= OCIOSO;
      cnt_q       <= 8'd0;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_end_q   <= 32'd0;
      mem_dado_q  <= 32'd0;
      mem_be_q    <= 4'b0000;
      done_q      <= 1'b0;
      erro_q      <= 1'b0;
      causa_q     <= CAUSA_NENHUMA;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_end_q   <= mem_end_d;
      mem_dado_q  <= mem_dado_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      erro_q      <= erro_d;
      causa_q     <= causa_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign mem_valid    = mem_valid_q;
  assign mem_endereco = mem_end_q;
  assign mem_dado     = mem_dado_q;
  assign mem_byte_en  = mem_be_q;
  assign done         = done_q;
  assign erro         = erro_q;
  assign erro_causa   = causa_q;

endmodule

// File: tb/tb_unidade_de_store.sv
// Purpose: directed bench for unidade_de_store (default MAX_WAIT and MAX_WAIT=4 instances).
// Latency: n/a.
// Backpressure: mem_ready is driven per vector to exercise wait and timeout paths.
module tb_unidade_de_store;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel;        // 0: default-budget instance, 1: MAX_WAIT=4 instance
  logic        req_valid;
  logic [1:0]  req_tipo;
  logic [31:0] req_endereco;
  logic [31:0] req_dado;
  logic        mem_ready;

  logic        rv_a, rr_a, mv_a, dn_a, er_a;
  logic [31:0] me_a, md_a;
  logic [3:0]  mb_a;
  logic [1:0]  ec_a;
  logic        rv_b, rr_b, mv_b, dn_b, er_b;
  logic [31:0] me_b, md_b;
  logic [3:0]  mb_b;
  logic [1:0]  ec_b;

  logic        o_req_ready, o_mem_valid, o_done, o_erro;
  logic [31:0] o_mem_end, o_mem_dado;
  logic [3:0]  o_mem_be;
  logic [1:0]  o_causa;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  assign rv_a = req_valid & ~sel;
  assign rv_b = req_valid & sel;

  assign o_req_ready = sel ? rr_b : rr_a;
  assign o_mem_valid = sel ? mv_b : mv_a;
  assign o_mem_end   = sel ? me_b : me_a;
  assign o_mem_dado  = sel ? md_b : md_a;
  assign o_mem_be    = sel ? mb_b : mb_a;
  assign o_done      = sel ? dn_b : dn_a;
  assign o_erro      = sel ? er_b : er_a;
  assign o_causa     = sel ? ec_b : ec_a;

  unidade_de_store dut_a (
    .clock(clock), .reset(reset),
    .req_valid(rv_a), .req_ready(rr_a), .req_tipo(req_tipo),
    .req_endereco(req_endereco), .req_dado(req_dado),
    .mem_valid(mv_a), .mem_ready(mem_ready), .mem_endereco(me_a),
    .mem_dado(md_a), .mem_byte_en(mb_a),
    .done(dn_a), .erro(er_a), .erro_causa(ec_a)
  );

  unidade_de_store #(.MAX_WAIT(4)) dut_b (
    .clock(clock), .reset(reset),
    .req_valid(rv_b), .req_ready(rr_b), .req_tipo(req_tipo),
    .req_endereco(req_endereco), .req_dado(req_dado),
    .mem_valid(mv_b), .mem_ready(mem_ready), .mem_endereco(me_b),
    .mem_dado(md_b), .mem_byte_en(mb_b),
    .done(dn_b), .erro(er_b), .erro_causa(ec_b)
  );

  typedef struct {
    logic [1:0]  tipo;
    logic [31:0] ender;
    logic [31:0] dado;
    int          atraso;   // mem_valid cycles with mem_ready low before the handshake
    logic [31:0] e_end;
    logic [31:0] e_dado;
    logic [3:0]  e_be;
    logic [1:0]  e_causa;  // 00 means the store must succeed
  } vec_t;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nome, act, exp);
    end
  endtask

  task automatic chk1(input string nome, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nome, act, exp);
    end
  endtask

  // Issue one request at the next negedge and follow it cycle by cycle.
  task automatic run_vec(input vec_t v);
    @(negedge clock);
    chk1("idle_req_ready", o_req_ready, 1'b1);
    req_valid    = 1'b1;
    req_tipo     = v.tipo;
    req_endereco = v.ender;
    req_dado     = v.dado;
    mem_ready    = 1'b0;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= v.atraso + 3; c++) begin
      @(negedge clock);
      if (v.e_causa != 2'b00) begin
        if (c == 1) begin
          chk1("bad_done", o_done, 1'b1);
          chk1("bad_erro", o_erro, 1'b1);
          chk("bad_causa", 32'(o_causa), 32'(v.e_causa));
          chk1("bad_no_mem_valid", o_mem_valid, 1'b0);
          chk("bad_be_zero", 32'(o_mem_be), 32'd0);
        end else if (c == 2) begin
          chk1("bad_done_drop", o_done, 1'b0);
          chk1("bad_ready_back", o_req_ready, 1'b1);
          chk1("bad_still_no_mem", o_mem_valid, 1'b0);
        end
      end else if (c <= v.atraso + 1) begin
        chk1("wr_mem_valid", o_mem_valid, 1'b1);
        chk("wr_endereco", o_mem_end, v.e_end);
        chk("wr_dado", o_mem_dado, v.e_dado);
        chk("wr_byte_en", 32'(o_mem_be), 32'(v.e_be));
        chk1("wr_no_done", o_done, 1'b0);
        chk1("wr_req_ready", o_req_ready, 1'b0);
      end else if (c == v.atraso + 2) begin
        chk1("ok_done", o_done, 1'b1);
        chk1("ok_erro", o_erro, 1'b0);
        chk("ok_causa", 32'(o_causa), 32'd0);
        chk1("ok_mem_valid_low", o_mem_valid, 1'b0);
        chk("ok_be_zero", 32'(o_mem_be), 32'd0);
        chk1("ok_req_ready_low", o_req_ready, 1'b0);
      end else begin
        chk1("ok_done_drop", o_done, 1'b0);
        chk1("ok_ready_back", o_req_ready, 1'b1);
      end
      mem_ready = (v.e_causa == 2'b00) && (c == v.atraso + 1);
    end
    mem_ready = 1'b0;
  endtask

  vec_t tab[12];

  initial begin
    tab[0]  = '{2'b00, 32'h1000_0003, 32'h1234_56AB, 0, 32'h1000_0000, 32'hABAB_ABAB, 4'b1000, 2'b00};
    tab[1]  = '{2'b01, 32'h0000_2002, 32'hFFFF_BEEF, 0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 2'b00};
    tab[2]  = '{2'b01, 32'h0000_2001, 32'hFFFF_BEEF, 0, 32'h0,         32'h0,         4'b0000, 2'b01};
    tab[3]  = '{2'b10, 32'h0000_0040, 32'hDEAD_BEEF, 5, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 2'b00};
    tab[4]  = '{2'b11, 32'h0000_0003, 32'h0000_0001, 0, 32'h0,         32'h0,         4'b0000, 2'b10};
    tab[5]  = '{2'b00, 32'h0000_0005, 32'hCAFE_0077, 1, 32'h0000_0004, 32'h7777_7777, 4'b0010, 2'b00};
    tab[6]  = '{2'b01, 32'h0000_0010, 32'h0000_1234, 2, 32'h0000_0010, 32'h1234_1234, 4'b0011, 2'b00};
    tab[7]  = '{2'b10, 32'h0000_0042, 32'h0102_0304, 0, 32'h0,         32'h0,         4'b0000, 2'b01};
    tab[8]  = '{2'b01, 32'h0000_0003, 32'h0000_5555, 0, 32'h0,         32'h0,         4'b0000, 2'b01};
    tab[9]  = '{2'b11, 32'h0000_0008, 32'h0000_0000, 0, 32'h0,         32'h0,         4'b0000, 2'b10};
    tab[10] = '{2'b00, 32'hFFFF_FFF0, 32'h0000_005A, 0, 32'hFFFF_FFF0, 32'h5A5A_5A5A, 4'b0001, 2'b00};
    tab[11] = '{2'b00, 32'h0000_0006, 32'h0000_00C3, 0, 32'h0000_0004, 32'hC3C3_C3C3, 4'b0100, 2'b00};

    sel          = 1'b0;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_tipo     = 2'b00;
    req_endereco = 32'd0;
    req_dado     = 32'd0;
    mem_ready    = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk1("rst_req_ready", o_req_ready, 1'b1);
    chk1("rst_mem_valid", o_mem_valid, 1'b0);
    chk("rst_endereco", o_mem_end, 32'd0);
    chk("rst_dado", o_mem_dado, 32'd0);
    chk("rst_byte_en", 32'(o_mem_be), 32'd0);
    chk1("rst_done", o_done, 1'b0);
    chk1("rst_erro", o_erro, 1'b0);
    chk("rst_causa", 32'(o_causa), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(tab[i]);

    // MAX_WAIT=4, memory never answers: exactly 4 write cycles, then timeout.
    sel = 1'b1;
    @(negedge clock);
    req_valid = 1'b1; req_tipo = 2'b10; req_endereco = 32'h0000_0100; req_dado = 32'h0BAD_F00D;
    mem_ready = 1'b0;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (c <= 4) begin
        chk1("to_mem_valid", o_mem_valid, 1'b1);
        chk1("to_no_done", o_done, 1'b0);
      end else if (c == 5) begin
        chk1("to_mem_valid_low", o_mem_valid, 1'b0);
        chk1("to_done", o_done, 1'b1);
        chk1("to_erro", o_erro, 1'b1);
        chk("to_causa", 32'(o_causa), 32'd3);
      end else begin
        chk1("to_done_drop", o_done, 1'b0);
        chk1("to_ready_back", o_req_ready, 1'b1);
      end
    end

    // MAX_WAIT=4, mem_ready arrives on the final allowed cycle: success.
    run_vec('{2'b10, 32'h0000_0104, 32'h1357_9BDF, 3, 32'h0000_0104, 32'h1357_9BDF, 4'b1111, 2'b00});
    run_vec('{2'b11, 32'h0000_0000, 32'h0, 0, 32'h0, 32'h0, 4'b0000, 2'b10});

    // Reset during the second ESCRITA cycle abandons the store silently.
    sel = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_tipo = 2'b10; req_endereco = 32'h0000_0200; req_dado = 32'h2468_ACE0;
    mem_ready = 1'b0;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    chk1("mr_valid_c1", o_mem_valid, 1'b1);
    @(negedge clock);
    chk1("mr_valid_c2", o_mem_valid, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk1("mr_valid_drop", o_mem_valid, 1'b0);
    chk1("mr_ready", o_req_ready, 1'b1);
    chk1("mr_no_done", o_done, 1'b0);
    chk("mr_be_zero", 32'(o_mem_be), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk1("mr_no_done_after", o_done, 1'b0);
    chk1("mr_still_idle", o_mem_valid, 1'b0);

    // req_valid held high: one store per acceptance, next accepted at edge 3.
    @(negedge clock);
    req_valid = 1'b1; req_tipo = 2'b10; req_endereco = 32'h0000_0080; req_dado = 32'h1122_3344;
    mem_ready = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      case (c)
        1: begin chk1("hold_c1_valid", o_mem_valid, 1'b1); chk1("hold_c1_ready", o_req_ready, 1'b0); end
        2: begin chk1("hold_c2_done", o_done, 1'b1); chk1("hold_c2_valid", o_mem_valid, 1'b0); end
        3: begin chk1("hold_c3_ready", o_req_ready, 1'b1); chk1("hold_c3_valid", o_mem_valid, 1'b0); end
        4: begin chk1("hold_c4_valid", o_mem_valid, 1'b1); chk1("hold_c4_ready", o_req_ready, 1'b0); end
        5: begin chk1("hold_c5_done", o_done, 1'b1); chk1("hold_c5_valid", o_mem_valid, 1'b0); end
        6: begin chk1("hold_c6_ready", o_req_ready, 1'b1); chk1("hold_c6_done", o_done, 1'b0); end
        default: begin chk1("hold_c7_valid", o_mem_valid, 1'b0); end
      endcase
      mem_ready = (c == 1) || (c == 4);
      if (c == 5) req_valid = 1'b0;
    end
    mem_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
